// File: rtl/larpix_cfg_responder.sv
// LArPix chip-side configuration responder: validates received packets, executes
// register writes/reads and returns reply packets. Optional macro CFG_RESP_FWD_EN forwards foreign packets.
module larpix_cfg_responder #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned REGNUM       = 256,
  parameter logic [31:0] MAGIC_NUMBER = 32'h8950_4E47,
  parameter logic [7:0]  GLOBAL_ID    = 8'd255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       chip_id,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       cfg_raddr,
  output logic [7:0]       cfg_rdata,
  output logic             cfg_wr_strobe,
  output logic [7:0]       cfg_wr_addr,
  output logic [7:0]       parity_err_cnt,
  output logic [7:0]       magic_err_cnt
);

  localparam logic [1:0] DECL_WRITE = 2'd2;
  localparam logic [1:0] DECL_READ  = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, REPLY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pkt_q, pkt_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             rx_ready_q, rx_ready_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       perr_q, perr_d;
  logic [7:0]       merr_q, merr_d;
  logic             fwd_q, fwd_d;
  logic [7:0]       regs_q [REGNUM];
  logic             reg_we;

  logic [1:0]       pkt_decl;
  logic [7:0]       pkt_id;
  logic [7:0]       pkt_addr;
  logic [7:0]       pkt_wdata;
  logic             par_ok, magic_ok, is_cfg, is_wr, id_match, addr_ok;
  logic [7:0]       reply_val;
  logic [WIDTH-1:0] reply_pkt;

  assign pkt_decl  = pkt_q[1:0];
  assign pkt_id    = pkt_q[9:2];
  assign pkt_addr  = pkt_q[17:10];
  assign pkt_wdata = pkt_q[25:18];
  assign par_ok    = (pkt_q[63] == ~^pkt_q[62:0]);
  assign magic_ok  = (pkt_q[57:26] == MAGIC_NUMBER);
  assign is_cfg    = (pkt_decl == DECL_WRITE) || (pkt_decl == DECL_READ);
  assign is_wr     = (pkt_decl == DECL_WRITE);
  assign id_match  = (pkt_id == chip_id) || (pkt_id == GLOBAL_ID);
  assign addr_ok   = (32'(pkt_addr) < REGNUM);

  assign cfg_rdata = (32'(cfg_raddr) < REGNUM) ? regs_q[cfg_raddr] : 8'h00;

  // Reply payload carries the post-write register value; out-of-range addresses read as 0.
  always_comb begin
    reply_val = 8'h00;
    if (addr_ok) reply_val = is_wr ? pkt_wdata : regs_q[pkt_addr];
    reply_pkt        = '0;
    reply_pkt[1:0]   = pkt_decl;
    reply_pkt[9:2]   = chip_id;
    reply_pkt[17:10] = pkt_addr;
    reply_pkt[25:18] = reply_val;
    reply_pkt[57:26] = MAGIC_NUMBER;
    reply_pkt[62]    = 1'b1;
    reply_pkt[63]    = ~^reply_pkt[62:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    tx_data_d = tx_data_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    perr_d    = perr_q;
    merr_d    = merr_q;
    fwd_d     = fwd_q;
    reg_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_ready_q) begin
          pkt_d   = rx_data;
          fwd_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!par_ok) begin
          if (perr_q != 8'hFF) perr_d = perr_q + 8'd1;
          state_d = IDLE;
        end else if (is_cfg && !magic_ok) begin
          if (merr_q != 8'hFF) merr_d = merr_q + 8'd1;
          state_d = IDLE;
        end else if (is_cfg && id_match) begin
          state_d = EXEC;
          if (is_wr && addr_ok) begin
            strobe_d  = 1'b1;
            wr_addr_d = pkt_addr;
          end
        end else begin
`ifdef CFG_RESP_FWD_EN
          // Forwarded packets pass through EXEC so all replies share the same latency.
          fwd_d   = 1'b1;
          state_d = EXEC;
`else
          state_d = IDLE;
`endif
        end
      end
      EXEC: begin
        if (fwd_q) begin
          tx_data_d = pkt_q;
        end else begin
          reg_we    = is_wr && addr_ok;
          tx_data_d = reply_pkt;
        end
        state_d = REPLY;
      end
      REPLY: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE);
    tx_valid_d = (state_d == REPLY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b1;
      strobe_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      perr_q     <= 8'h00;
      merr_q     <= 8'h00;
      fwd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      strobe_q   <= strobe_d;
      wr_addr_q  <= wr_addr_d;
      perr_q     <= perr_d;
      merr_q     <= merr_d;
      fwd_q      <= fwd_d;
    end
  end

  // Configuration register map.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: 8'h00};
    end else if (reg_we) begin
      regs_q[pkt_addr] <= pkt_wdata;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign cfg_wr_strobe  = strobe_q;
  assign cfg_wr_addr    = wr_addr_q;
  assign parity_err_cnt = perr_q;
  assign magic_err_cnt  = merr_q;

endmodule

// File: tb/tb_larpix_cfg_responder.sv
// Directed self-checking bench for larpix_cfg_responder.
module tb_larpix_cfg_responder;

  localparam logic [31:0] MAGIC = 32'h8950_4E47;

  logic        clk;
  logic        reset_n;
  logic [7:0]  chip_id;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  cfg_raddr;
  logic [7:0]  cfg_rdata;
  logic        cfg_wr_strobe;
  logic [7:0]  cfg_wr_addr;
  logic [7:0]  parity_err_cnt;
  logic [7:0]  magic_err_cnt;

  int total = 0;
  int bad   = 0;

  larpix_cfg_responder dut (
    .clk(clk), .reset_n(reset_n), .chip_id(chip_id),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
    .cfg_wr_strobe(cfg_wr_strobe), .cfg_wr_addr(cfg_wr_addr),
    .parity_err_cnt(parity_err_cnt), .magic_err_cnt(magic_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [1:0] d, input logic [7:0] id,
                                     input logic [7:0] a, input logic [7:0] v,
                                     input logic [31:0] m, input logic down,
                                     input logic flip);
    logic [63:0] p;
    p = '0;
    p[1:0] = d; p[9:2] = id; p[17:10] = a; p[25:18] = v; p[57:26] = m; p[62] = down;
    p[63] = ~^p[62:0];
    if (flip) p[63] = ~p[63];
    return p;
  endfunction

  // Presents p for one cycle; returns at the negedge of the CHECK cycle (N+1).
  task automatic send(input logic [63:0] p);
    @(negedge clk); rx_data = p; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; chip_id = 8'd0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1; cfg_raddr = 8'd1;
    #22;
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 64'h0) begin bad++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    total++; if (cfg_wr_strobe !== 1'b0 || cfg_wr_addr !== 8'h00) begin bad++; $display("FAIL reset_wr got=%b/%h exp=0/00", cfg_wr_strobe, cfg_wr_addr); end
    total++; if (parity_err_cnt !== 8'h00 || magic_err_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=00/00", parity_err_cnt, magic_err_cnt); end
    total++; if (cfg_rdata !== 8'h00) begin bad++; $display("FAIL reset_reg got=%h exp=00", cfg_rdata); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_write;
    logic [63:0] exp;
    chip_id = 8'd0; tx_ready = 1'b1; cfg_raddr = 8'd1;
    exp = mk(2'd2, 8'd0, 8'd1, 8'hA5, MAGIC, 1'b1, 1'b0);
    send(mk(2'd2, 8'd0, 8'd1, 8'hA5, MAGIC, 1'b0, 1'b0));
    total++; if (rx_ready !== 1'b0 || cfg_wr_strobe !== 1'b0) begin bad++; $display("FAIL wr_n1 rx_ready/strobe got=%b/%b exp=0/0", rx_ready, cfg_wr_strobe); end
    @(negedge clk);
    total++; if (cfg_wr_strobe !== 1'b1 || cfg_wr_addr !== 8'd1 || tx_valid !== 1'b0) begin bad++; $display("FAIL wr_strobe got=%b/%h/%b exp=1/01/0", cfg_wr_strobe, cfg_wr_addr, tx_valid); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL wr_reply got=%b/%h exp=1/%h", tx_valid, tx_data, exp); end
    total++; if (cfg_wr_strobe !== 1'b0 || cfg_rdata !== 8'hA5) begin bad++; $display("FAIL wr_after got=%b/%h exp=0/a5", cfg_wr_strobe, cfg_rdata); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL wr_done got=%b/%b exp=0/1", tx_valid, rx_ready); end
  endtask

  task automatic test_read_backpressure;
    logic [63:0] exp;
    exp = mk(2'd3, 8'd0, 8'd1, 8'hA5, MAGIC, 1'b1, 1'b0);
    tx_ready = 1'b0;
    send(mk(2'd3, 8'd0, 8'd1, 8'h00, MAGIC, 1'b0, 1'b0));
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL rd_hold[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp); end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rd_release got=%b exp=0", tx_valid); end
  endtask

  task automatic test_broadcast;
    logic [63:0] exp;
    chip_id = 8'd16; cfg_raddr = 8'd7;
    exp = mk(2'd2, 8'd16, 8'd7, 8'h3C, MAGIC, 1'b1, 1'b0);
    send(mk(2'd2, 8'd255, 8'd7, 8'h3C, MAGIC, 1'b0, 1'b0));
    @(negedge clk);
    total++; if (cfg_wr_strobe !== 1'b1 || cfg_wr_addr !== 8'd7) begin bad++; $display("FAIL bc_strobe got=%b/%h exp=1/07", cfg_wr_strobe, cfg_wr_addr); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL bc_reply got=%b/%h exp=1/%h", tx_valid, tx_data, exp); end
    total++; if (cfg_rdata !== 8'h3C) begin bad++; $display("FAIL bc_reg got=%h exp=3c", cfg_rdata); end
    @(negedge clk);
    chip_id = 8'd0;
  endtask

  task automatic test_errors;
    logic seen_tx, seen_wr;
    cfg_raddr = 8'd2;
    seen_tx = 1'b0; seen_wr = 1'b0;
    send(mk(2'd2, 8'd0, 8'd2, 8'h55, MAGIC, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      seen_tx |= tx_valid; seen_wr |= cfg_wr_strobe; @(negedge clk);
    end
    total++; if (seen_tx || seen_wr) begin bad++; $display("FAIL par_drop tx/wr got=%b/%b exp=0/0", seen_tx, seen_wr); end
    total++; if (parity_err_cnt !== 8'd1 || cfg_rdata !== 8'h00) begin bad++; $display("FAIL par_cnt got=%h reg=%h exp=01/00", parity_err_cnt, cfg_rdata); end
    seen_tx = 1'b0;
    send(mk(2'd3, 8'd0, 8'd1, 8'h00, 32'h0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      seen_tx |= tx_valid; @(negedge clk);
    end
    total++; if (seen_tx || magic_err_cnt !== 8'd1 || parity_err_cnt !== 8'd1) begin bad++; $display("FAIL magic got tx=%b m=%h p=%h exp=0/01/01", seen_tx, magic_err_cnt, parity_err_cnt); end
    for (int i = 0; i < 253; i++) send(mk(2'd3, 8'd0, 8'd1, 8'h00, 32'h0, 1'b0, 1'b1));
    @(negedge clk);
    total++; if (parity_err_cnt !== 8'd254) begin bad++; $display("FAIL par_254 got=%0d exp=254", parity_err_cnt); end
    for (int i = 0; i < 46; i++) send(mk(2'd3, 8'd0, 8'd1, 8'h00, 32'h0, 1'b0, 1'b1));
    @(negedge clk);
    total++; if (parity_err_cnt !== 8'd255 || magic_err_cnt !== 8'd1) begin bad++; $display("FAIL par_sat got=%0d m=%0d exp=255/1", parity_err_cnt, magic_err_cnt); end
  endtask

  task automatic test_other_chip;
    logic [63:0] p;
    logic seen_tx;
    p = mk(2'd2, 8'd31, 8'd3, 8'h77, MAGIC, 1'b0, 1'b0);
    seen_tx = 1'b0;
    send(p);
    @(negedge clk);
    seen_tx |= tx_valid;
    total++; if (cfg_wr_strobe !== 1'b0) begin bad++; $display("FAIL oc_strobe got=%b exp=0", cfg_wr_strobe); end
    @(negedge clk);
`ifdef CFG_RESP_FWD_EN
    total++; if (tx_valid !== 1'b1 || tx_data !== p) begin bad++; $display("FAIL oc_fwd got=%b/%h exp=1/%h", tx_valid, tx_data, p); end
    @(negedge clk);
`else
    seen_tx |= tx_valid; @(negedge clk); seen_tx |= tx_valid;
    total++; if (seen_tx !== 1'b0) begin bad++; $display("FAIL oc_drop got=%b exp=0", seen_tx); end
`endif
    total++; if (parity_err_cnt !== 8'd255 || magic_err_cnt !== 8'd1) begin bad++; $display("FAIL oc_cnt got=%0d/%0d exp=255/1", parity_err_cnt, magic_err_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_w, exp_r;
    exp_w = mk(2'd2, 8'd0, 8'd9, 8'h5A, MAGIC, 1'b1, 1'b0);
    exp_r = mk(2'd3, 8'd0, 8'd9, 8'h5A, MAGIC, 1'b1, 1'b0);
    @(negedge clk); rx_data = mk(2'd2, 8'd0, 8'd9, 8'h5A, MAGIC, 1'b0, 1'b0); rx_valid = 1'b1;
    @(negedge clk); rx_data = mk(2'd3, 8'd0, 8'd9, 8'h00, MAGIC, 1'b0, 1'b0);
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", rx_ready); end
    @(negedge clk);
    total++; if (cfg_wr_strobe !== 1'b1 || cfg_wr_addr !== 8'd9) begin bad++; $display("FAIL b2b_strobe got=%b/%h exp=1/09", cfg_wr_strobe, cfg_wr_addr); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== exp_w) begin bad++; $display("FAIL b2b_wreply got=%b/%h exp=1/%h", tx_valid, tx_data, exp_w); end
    @(negedge clk);
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== exp_r) begin bad++; $display("FAIL b2b_rreply got=%b/%h exp=1/%h", tx_valid, tx_data, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp;
    tx_ready = 1'b0; cfg_raddr = 8'd1;
    send(mk(2'd3, 8'd0, 8'd1, 8'h00, MAGIC, 1'b0, 1'b0));
    @(negedge clk); @(negedge clk);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b exp=1", tx_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL rm_abort got=%b/%b exp=0/1", tx_valid, rx_ready); end
    total++; if (cfg_rdata !== 8'h00 || parity_err_cnt !== 8'h00 || magic_err_cnt !== 8'h00) begin bad++; $display("FAIL rm_clear got=%h/%h/%h exp=00/00/00", cfg_rdata, parity_err_cnt, magic_err_cnt); end
    #4 reset_n = 1'b1;
    tx_ready = 1'b1;
    exp = mk(2'd3, 8'd0, 8'd1, 8'h00, MAGIC, 1'b1, 1'b0);
    send(mk(2'd3, 8'd0, 8'd1, 8'h00, MAGIC, 1'b0, 1'b0));
    @(negedge clk); @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== exp) begin bad++; $display("FAIL rm_read got=%b/%h exp=1/%h", tx_valid, tx_data, exp); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_broadcast();
    test_errors();
    test_other_chip();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
